branch_resolve_unit: RTL and testbench

Resolution-side partner of the bimodal predictor. It queues every prediction issued at fetch and compares each against the actual outcome when the branch resolves in EX/MEM. On a mismatch it raises FLUSH and a redirect PC. Every resolved branch is reported back to the predictor's BTB/PHT update inputs, and branch and mispredict counts are kept for performance reporting.

---
 rtl/branch_resolve_unit_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 153 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - prediction, resolution and redirect/update bundle
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic              Pred_valid;
  logic              Pred_taken;
  logic [31:0]       Pred_target;
  logic [31:0]       Pred_pc;
  logic              Res_valid;
  logic              Res_taken;
  logic [31:0]       Res_target;
  logic [31:0]       Res_pc;
  logic              FLUSH;
  logic              Redirect_valid;
  logic [31:0]       Redirect_addr;
  logic              Update_valid;
  logic              Branch_resolved;
  logic [31:0]       Branch_resolved_addr;
  logic [31:0]       Branch_addr;
  logic [CNT_W-1:0]  Branch_count;
  logic [CNT_W-1:0]  Mispredict_count;
  logic              Overflow;

  modport master (
    output Pred_valid, Pred_taken, Pred_target, Pred_pc,
    output Res_valid, Res_taken, Res_target, Res_pc,
    input  FLUSH, Redirect_valid, Redirect_addr, Update_valid,
    input  Branch_resolved, Branch_resolved_addr, Branch_addr,
    input  Branch_count, Mispredict_count, Overflow
  );

  modport slave (
    input  Pred_valid, Pred_taken, Pred_target, Pred_pc,
    input  Res_valid, Res_taken, Res_target, Res_pc,
    output FLUSH, Redirect_valid, Redirect_addr, Update_valid,
    output Branch_resolved, Branch_resolved_addr, Branch_addr,
    output Branch_count, Mispredict_count, Overflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-flight prediction queue, mispredict detection, flush and predictor update
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  branch_resolve_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {NORMAL, FLUSHING} state_t;

  state_t            state, state_next;
  logic [FW-1:0]     fcnt, fcnt_next;

  logic              q_taken  [DEPTH];
  logic [31:0]       q_target [DEPTH];
  logic [31:0]       q_pc     [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [OW-1:0]     occ;

  logic              empty, full;
  logic              accept_res, mispredict, pc_mismatch;
  logic              do_pop, do_push, push_drop;

  logic              flush_r, redirect_valid_r, update_valid_r, resolved_r, ovf_r;
  logic [31:0]       redirect_addr_r, resolved_addr_r, branch_addr_r;
  logic [CNT_W-1:0]  bcnt, mcnt;

  assign empty = (occ == '0);
  assign full  = (occ == OW'(DEPTH));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= NORMAL;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // Head is compared before this edge's push lands, so a same-edge push never satisfies a pop.
  always_comb begin
    state_next  = state;
    fcnt_next   = fcnt;
    accept_res  = 1'b0;
    mispredict  = 1'b0;
    pc_mismatch = 1'b0;
    do_pop      = 1'b0;
    do_push     = 1'b0;
    push_drop   = 1'b0;
    case (state)
      NORMAL: begin
        accept_res = bus.Res_valid;
        if (bus.Res_valid) begin
          if (empty) begin
            mispredict = 1'b1;
          end else begin
            do_pop      = 1'b1;
            pc_mismatch = (q_pc[head] != bus.Res_pc);
            mispredict  = pc_mismatch
                       || (q_taken[head] != bus.Res_taken)
                       || (bus.Res_taken && (q_target[head] != bus.Res_target));
          end
        end
        if (bus.Pred_valid) begin
          if (!full || do_pop) do_push   = 1'b1;
          else                 push_drop = 1'b1;
        end
        if (mispredict) begin
          state_next = FLUSHING;
          fcnt_next  = FW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSHING: begin
        if (fcnt == '0) state_next = NORMAL;
        else            fcnt_next  = fcnt - FW'(1);
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      q_taken[tail]  <= bus.Pred_taken;
      q_target[tail] <= bus.Pred_target;
      q_pc[tail]     <= bus.Pred_pc;
    end
  end

  // A mispredict discards everything in flight, including any push on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET || mispredict) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      update_valid_r   <= 1'b0;
      resolved_r       <= 1'b0;
      ovf_r            <= 1'b0;
      redirect_addr_r  <= '0;
      resolved_addr_r  <= '0;
      branch_addr_r    <= '0;
      bcnt             <= '0;
      mcnt             <= '0;
    end else begin
      flush_r          <= (state_next == FLUSHING);
      redirect_valid_r <= mispredict;
      update_valid_r   <= accept_res;
      if (accept_res) begin
        resolved_r      <= bus.Res_taken;
        resolved_addr_r <= bus.Res_target;
        branch_addr_r   <= bus.Res_pc;
        if (bcnt != '1) bcnt <= bcnt + CNT_W'(1);
      end
      if (mispredict) begin
        redirect_addr_r <= bus.Res_taken ? bus.Res_target : bus.Res_pc + 32'd8;
        if (mcnt != '1) mcnt <= mcnt + CNT_W'(1);
      end
      if (push_drop || pc_mismatch) ovf_r <= 1'b1;
    end
  end

  assign bus.FLUSH                = flush_r;
  assign bus.Redirect_valid       = redirect_valid_r;
  assign bus.Redirect_addr        = redirect_addr_r;
  assign bus.Update_valid         = update_valid_r;
  assign bus.Branch_resolved      = resolved_r;
  assign bus.Branch_resolved_addr = resolved_addr_r;
  assign bus.Branch_addr          = branch_addr_r;
  assign bus.Branch_count         = bcnt;
  assign bus.Mispredict_count     = mcnt;
  assign bus.Overflow             = ovf_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed bench for branch_resolve_unit against a queue-level model
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int CNT_W = 32;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic        t;
    logic [31:0] tg;
    logic [31:0] pc;
  } pred_t;

  pred_t            mq[$];
  int               flush_left = 0;
  logic             e_flush = 0, e_rv = 0, e_uv = 0, e_br = 0, e_ovf = 0;
  logic [31:0]      e_ra = 0, e_bra = 0, e_ba = 0;
  logic [CNT_W-1:0] e_bc = 0, e_mc = 0;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model(input logic rst, input logic pv, input logic pt, input logic [31:0] ptg,
                       input logic [31:0] ppc, input logic rv, input logic rt,
                       input logic [31:0] rtg, input logic [31:0] rpc);
    pred_t h;
    bit    mis;
    if (!rst) begin
      mq.delete();
      flush_left = 0;
      e_flush = 0; e_rv = 0; e_uv = 0; e_br = 0; e_ovf = 0;
      e_ra = 0; e_bra = 0; e_ba = 0; e_bc = 0; e_mc = 0;
      return;
    end
    e_uv = 0;
    e_rv = 0;
    if (flush_left > 0) begin
      flush_left--;
      e_flush = (flush_left > 0);
      return;
    end
    mis = 0;
    if (rv) begin
      e_uv = 1; e_br = rt; e_bra = rtg; e_ba = rpc;
      if (e_bc != '1) e_bc = e_bc + 1;
      if (mq.size() == 0) mis = 1;
      else begin
        h = mq.pop_front();
        if (h.pc != rpc) begin mis = 1; e_ovf = 1; end
        if (h.t != rt) mis = 1;
        if (rt && h.tg != rtg) mis = 1;
      end
    end
    if (pv) begin
      if (mq.size() < DEPTH) mq.push_back('{pt, ptg, ppc});
      else e_ovf = 1;
    end
    if (mis) begin
      mq.delete();
      flush_left = FC;
      e_flush = 1;
      e_rv = 1;
      e_ra = rt ? rtg : rpc + 32'd8;
      if (e_mc != '1) e_mc = e_mc + 1;
    end else begin
      e_flush = 0;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("flush", bus.FLUSH, e_flush);
      chk("redirect_valid", bus.Redirect_valid, e_rv);
      chk("redirect_addr", bus.Redirect_addr, e_ra);
      chk("update_valid", bus.Update_valid, e_uv);
      chk("branch_resolved", bus.Branch_resolved, e_br);
      chk("branch_resolved_addr", bus.Branch_resolved_addr, e_bra);
      chk("branch_addr", bus.Branch_addr, e_ba);
      chk("branch_count", bus.Branch_count, e_bc);
      chk("mispredict_count", bus.Mispredict_count, e_mc);
      chk("overflow", bus.Overflow, e_ovf);
    end
  end

  task automatic step(input logic rst, input logic pv, input logic pt, input logic [31:0] ptg,
                      input logic [31:0] ppc, input logic rv, input logic rt,
                      input logic [31:0] rtg, input logic [31:0] rpc);
    RESET           = rst;
    bus.Pred_valid  = pv;
    bus.Pred_taken  = pt;
    bus.Pred_target = ptg;
    bus.Pred_pc     = ppc;
    bus.Res_valid   = rv;
    bus.Res_taken   = rt;
    bus.Res_target  = rtg;
    bus.Res_pc      = rpc;
    @(posedge CLK);
    model(rst, pv, pt, ptg, ppc, rv, rt, rtg, rpc);
    @(negedge CLK);
  endtask

  task automatic push(input logic t, input logic [31:0] tg, input logic [31:0] pc);
    step(1, 1, t, tg, pc, 0, 0, 0, 0);
  endtask

  task automatic res(input logic t, input logic [31:0] tg, input logic [31:0] pc);
    step(1, 0, 0, 0, 0, 1, t, tg, pc);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_flush", bus.FLUSH, 0);
    chk("reset_update_valid", bus.Update_valid, 0);
    chk("reset_redirect_addr", bus.Redirect_addr, 0);
    chk("reset_branch_count", bus.Branch_count, 0);
    chk("reset_overflow", bus.Overflow, 0);

    push(1, 32'h0040_0100, 32'h0040_0020);
    res(1, 32'h0040_0100, 32'h0040_0020);
    chk("taken_ok_update_valid", bus.Update_valid, 1);
    chk("taken_ok_branch_addr", bus.Branch_addr, 32'h0040_0020);
    chk("taken_ok_flush", bus.FLUSH, 0);
    chk("taken_ok_branch_count", bus.Branch_count, 1);
    chk("taken_ok_mispredict_count", bus.Mispredict_count, 0);

    push(0, 32'h0, 32'h0040_0040);
    res(1, 32'h0040_0200, 32'h0040_0040);
    chk("dir_mis_redirect_valid", bus.Redirect_valid, 1);
    chk("dir_mis_redirect_addr", bus.Redirect_addr, 32'h0040_0200);
    chk("dir_mis_flush_c1", bus.FLUSH, 1);
    chk("dir_mis_mispredict_count", bus.Mispredict_count, 1);
    push(0, 32'h0, 32'h0050_0000);
    chk("dir_mis_flush_c2", bus.FLUSH, 1);
    chk("dir_mis_redirect_pulse", bus.Redirect_valid, 0);
    idle();
    chk("dir_mis_flush_end", bus.FLUSH, 0);
    res(0, 32'h0, 32'h0050_0000);
    chk("flush_push_dropped", bus.Redirect_valid, 1);
    chk("empty_redirect_addr", bus.Redirect_addr, 32'h0050_0008);
    idle();
    idle();

    push(1, 32'h0040_0300, 32'hFFFF_FFFC);
    res(0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_redirect_addr", bus.Redirect_addr, 32'h0000_0004);
    chk("wrap_mispredict_count", bus.Mispredict_count, 3);
    idle();
    idle();

    for (int i = 0; i < 4; i++) push(i[0], 32'h3000 + 32'(i * 4), 32'h1000 + 32'(i * 4));
    chk("full_no_overflow_yet", bus.Overflow, 0);
    push(1, 32'h0, 32'h2000);
    chk("full_overflow", bus.Overflow, 1);
    for (int i = 0; i < 4; i++)
      step(1, (i < 2), 1, 32'h5000 + 32'(i * 4), 32'h1010 + 32'(i * 4),
           1, i[0], 32'h3000 + 32'(i * 4), 32'h1000 + 32'(i * 4));
    chk("wrap_branch_count", bus.Branch_count, 8);
    chk("wrap_no_mispredict", bus.Mispredict_count, 3);
    res(1, 32'h5000, 32'h1010);
    res(1, 32'h5004, 32'h1014);
    chk("drain_branch_count", bus.Branch_count, 10);
    chk("drain_flush", bus.FLUSH, 0);

    push(1, 32'h0060_0000, 32'h0040_0500);
    res(1, 32'h0060_0004, 32'h0040_0500);
    chk("target_mis_flush", bus.FLUSH, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midflush_reset_flush", bus.FLUSH, 0);
    chk("midflush_reset_bcount", bus.Branch_count, 0);
    chk("midflush_reset_mcount", bus.Mispredict_count, 0);
    chk("midflush_reset_overflow", bus.Overflow, 0);
    push(0, 32'h0, 32'h0040_0600);
    res(0, 32'h0, 32'h0040_0600);
    chk("post_reset_update", bus.Update_valid, 1);
    chk("post_reset_no_redirect", bus.Redirect_valid, 0);

    push(0, 32'h0, 32'h0040_0700);
    res(0, 32'h0, 32'h0040_0704);
    chk("pc_mis_redirect", bus.Redirect_valid, 1);
    chk("pc_mis_overflow", bus.Overflow, 1);
    chk("pc_mis_redirect_addr", bus.Redirect_addr, 32'h0040_070C);
    idle();
    idle();

    step(1, 1, 0, 32'h0, 32'h0040_0800, 1, 0, 32'h0, 32'h0040_0800);
    chk("same_edge_empty_mis", bus.Redirect_valid, 1);
    idle();
    idle();
    res(0, 32'h0, 32'h0040_0800);
    chk("same_edge_push_discarded", bus.Redirect_valid, 1);
    chk("final_mispredict_count", bus.Mispredict_count, 3);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
